// File: rtl/rv_pkg.sv
// Shared core types and constants for the fetch stage and its buffer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rv_pkg;

    localparam int              XLEN        = 32;
    localparam logic [XLEN-1:0] RV_NOP      = 32'h0000_0013;
    localparam logic [XLEN-1:0] RV_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect, decode handoff.
// Latency: wires only.
// Backpressure: imem via gnt, decode via id_ready; redirect cannot be stalled.
interface instr_fetch_if;
    import rv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries; flush beats push.
// Latency: a push is visible at the head one cycle later (no bypass).
// Backpressure: exposes full/count; the producer must never push while full.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       push_dat,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       pop_dat,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_en, pop_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_en = push && !flush;
    assign pop_en  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word fetches on credit, buffers returns for decode.
// Latency: grant in N, rvalid in N+1 -> id_valid in N+2; redirect in R -> new request in R+1.
// Backpressure: fetches stop once outstanding + buffered reach DEPTH; output held while !id_ready.
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RV_RESET_PC,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_fetch_if.master   bus
);

    localparam int             CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rpc_q, rpc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             run_q, run_d;

    logic             req, fire, push, pop;
    logic [CNT_W:0]   in_use;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    fetch_entry_t     push_dat, head;

    assign in_use   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign req      = run_q && !bus.redirect_valid && !fifo_full && (in_use < CREDITS);
    assign fire     = req && bus.imem_gnt;
    assign push     = bus.imem_rvalid && (drop_q == '0) && !bus.redirect_valid;
    assign pop      = !fifo_empty && bus.id_ready;
    // rpc_q tracks the address of the next non-discarded return; requests are sequential between redirects.
    assign push_dat = {bus.imem_rdata, rpc_q};

    always_comb begin
        pc_d          = pc_q;
        rpc_d         = rpc_q;
        drop_d        = drop_q;
        run_d         = 1'b1;
        outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(bus.imem_rvalid);
        if (bus.redirect_valid) begin
            pc_d   = word_align(bus.redirect_pc);
            rpc_d  = pc_d;
            drop_d = outstanding_d;
        end else begin
            if (fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (push) begin
                rpc_d = rpc_q + XLEN'(4);
            end
            if (bus.imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rpc_q         <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            run_q         <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rpc_q         <= rpc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            run_q         <= run_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (bus.redirect_valid),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = !fifo_empty;
    assign bus.id_instr  = fifo_empty ? RV_NOP : head.instr;
    assign bus.id_pc     = fifo_empty ? '0 : head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order memory model and a decode-side scoreboard.
module tb_instr_fetch;
    import rv_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           n_chk     = 0;
    int           n_fail    = 0;
    int           lat       = 1;
    int           cyc       = 0;
    int           grant_cnt = 0;
    int           g0;
    fetch_entry_t exp_q[$];
    pend_t        pend_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back('{instr: mem_word(pc), pc: pc});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Memory model: in-order responses, fixed latency captured at grant time.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_q.delete();
            end else begin
                if (bus.imem_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
                if (bus.imem_req && bus.imem_gnt) begin
                    pend_q.push_back('{addr: bus.imem_addr, due: cyc + lat});
                    grant_cnt++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend_q[0].addr);
            end else begin
                bus.imem_rvalid = 1'b0;
            end
        end
    end

    // Decode-side monitor: every transfer must match the head of the expected queue.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.id_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL id_unexpected: got transfer of pc %h, expected none", bus.id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc", bus.id_pc, e.pc);
                    check("id_instr", bus.id_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, expected the test to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_gnt       = 1'b1;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        #1 rst_n = 1'b0;

        // Reset state
        ticks(2);
        @(negedge clk);
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'h0000_0100);
        check("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check("rst_id_instr", bus.id_instr, 32'h0000_0013);
        check("rst_id_pc", bus.id_pc, 32'h0);

        // Reset fetch: 8 grants from 0x100, streamed with decode always ready
        for (int i = 0; i < 8; i++) expect_pc(32'h100 + 32'(4 * i));
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("start_req", 32'(bus.imem_req), 32'd1);
        check("start_addr0", bus.imem_addr, 32'h100);
        check("lat_valid_c1", 32'(bus.id_valid), 32'd0);
        tick();
        @(negedge clk);
        check("start_addr1", bus.imem_addr, 32'h104);
        check("lat_valid_c2", 32'(bus.id_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_valid_c3", 32'(bus.id_valid), 32'd1);
        check("lat_pc_c3", bus.id_pc, 32'h100);
        check("start_addr2", bus.imem_addr, 32'h108);
        ticks(6);
        bus.imem_gnt = 1'b0;
        ticks(2);
        @(negedge clk);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: decode stalled for 10 cycles
        tick();
        bus.id_ready = 1'b0;
        bus.imem_gnt = 1'b1;
        g0 = grant_cnt;
        for (int i = 0; i < 4; i++) expect_pc(32'h120 + 32'(4 * i));
        ticks(10);
        @(negedge clk);
        check("bp_grants", 32'(grant_cnt - g0), 32'd4);
        check("bp_req_low", 32'(bus.imem_req), 32'd0);
        check("bp_valid", 32'(bus.id_valid), 32'd1);
        check("bp_pc_hold", bus.id_pc, 32'h120);
        check("bp_instr_hold", bus.id_instr, mem_word(32'h120));
        ticks(2);
        @(negedge clk);
        check("bp_pc_hold2", bus.id_pc, 32'h120);
        check("bp_instr_hold2", bus.id_instr, mem_word(32'h120));
        tick();
        bus.id_ready = 1'b1;
        bus.imem_gnt = 1'b0;
        ticks(6);
        @(negedge clk);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Redirect with three fetches in flight (latency 3)
        tick();
        lat = 3;
        bus.imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(32'h2000 + 32'(4 * i));
        ticks(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2002;
        @(negedge clk);
        check("redir_req_low", 32'(bus.imem_req), 32'd0);
        check("redir_stale_rvalid", 32'(bus.imem_rvalid), 32'd1);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_req", 32'(bus.imem_req), 32'd1);
        check("redir_addr", bus.imem_addr, 32'h2000);
        ticks(4);
        bus.imem_gnt = 1'b0;
        ticks(8);
        @(negedge clk);
        check("redir_drained", 32'(exp_q.size()), 32'd0);

        // Redirect coinciding with rvalid and an id handshake, then wrap
        tick();
        lat = 1;
        bus.imem_gnt = 1'b1;
        bus.id_ready = 1'b0;
        expect_pc(32'h2010);
        expect_pc(32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        ticks(4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        bus.id_ready       = 1'b1;
        @(negedge clk);
        check("simul_rvalid", 32'(bus.imem_rvalid), 32'd1);
        check("simul_id_valid", 32'(bus.id_valid), 32'd1);
        check("simul_id_pc", bus.id_pc, 32'h2010);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("simul_flushed", 32'(bus.id_valid), 32'd0);
        check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
        tick();
        @(negedge clk);
        check("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("wrap_addr2", bus.imem_addr, 32'h0000_0000);
        tick();
        bus.imem_gnt = 1'b0;
        ticks(4);
        @(negedge clk);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-burst
        tick();
        bus.imem_gnt = 1'b1;
        ticks(2);
        #1;
        check("arst_pre_valid", 32'(bus.id_valid), 32'd1);
        check("arst_pre_req", 32'(bus.imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(bus.imem_req), 32'd0);
        check("arst_valid", 32'(bus.id_valid), 32'd0);
        check("arst_addr", bus.imem_addr, 32'h100);
        @(negedge clk);
        ticks(2);
        expect_pc(32'h100);
        expect_pc(32'h104);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("restart_req", 32'(bus.imem_req), 32'd1);
        check("restart_addr0", bus.imem_addr, 32'h100);
        tick();
        @(negedge clk);
        check("restart_addr1", bus.imem_addr, 32'h104);
        tick();
        bus.imem_gnt = 1'b0;
        ticks(5);
        @(negedge clk);
        check("restart_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-issue RISC-V core. It owns the program counter, issues word fetches to instruction memory and buffers the returned words. It then presents `{instr, pc}` to decode through a valid/ready handshake. Decode slices `id_instr` into the immediate generator and register-file fields. Branch/jump redirects from execute flush in-flight and buffered fetches.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `DEPTH`, 4: instruction buffer entries. This is also the maximum number of fetches that are outstanding or buffered. Must be a power of two, ≥2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch byte address; always word-aligned.
- `imem_gnt`  in  1  memory accepts the request this cycle; meaningful only while `imem_req`=1.
- `imem_rvalid`  in  1  response valid. Responses are in order, at least 1 cycle after their grant.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  execute requests a PC change.
- `redirect_pc`  in  32  new PC; bits [1:0] are ignored and forced to 0.
- `id_valid`  out  1  `id_instr`/`id_pc` hold a fetched instruction.
- `id_ready`  in  1  decode accepts this cycle.
- `id_instr`  out  32  instruction word to decode.
- `id_pc`  out  32  address of `id_instr`.

## Operation
- **Registers**
  - `pc`: next address to request.
  - `outstanding`: granted requests not yet returned; width $clog2(DEPTH+1).
  - `drop`: returns still to be discarded.
  - FIFO of `{instr, pc}`.
  - A PC-tag FIFO, or a pc field carried per request, so every buffered entry knows its address.
- **Issue:** `imem_req`=1 when `outstanding + occupancy < DEPTH` and `redirect_valid`=0. `imem_addr`=`pc`.
- **Grant:** on `imem_req && imem_gnt`, set `pc <= pc+4` (32-bit wrap: 0xFFFF_FFFC → 0x0000_0000) and increment `outstanding`.
- **Return:** on `imem_rvalid`, decrement `outstanding`.
  - If `drop`>0, discard the word and decrement `drop`.
  - Otherwise push `{imem_rdata, request pc}`.
  - The FIFO can never overflow, because of the credit rule. A push while full is an assertion failure.
- **Pop:** on `id_valid && id_ready`, advance to the next entry.
- **Redirect:** in a cycle with `redirect_valid`=1:
  - `pc <= {redirect_pc[31:2],2'b00}`.
  - Flush the FIFO.
  - `drop <=` the number of requests that will still return, i.e. outstanding after this cycle's grant/return accounting, with the returning word (if any) discarded.
  - `imem_req` is forced to 0 that cycle.
- **Simultaneous events**
  - Redirect with rvalid: the returning word is discarded.
  - Redirect with an id handshake: the transfer completes. The killed instruction is squashed downstream by execute.
  - Consecutive redirects: the last one wins; `drop` is recomputed each time.
- **Stalls:** `id_valid` and `id_ready` obey the standard handshake. While `id_valid && !id_ready`, `id_instr`/`id_pc` are held stable. `id_valid` never deasserts without a pop, except on redirect.

## Timing
- **Reset values (asserted asynchronously):**
  - `pc`=`RESET_PC`, `outstanding`=0, `drop`=0, FIFO empty.
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_instr`=32'h0000_0013 (NOP), `id_pc`=0.
- **Startup:** `imem_req` rises in the first cycle after `rst_n` deasserts.
- **Latency:** with grant in cycle N and rvalid in N+1, `id_valid`=1 in N+2 (FIFO output registered, no bypass).
- **Throughput:** with `DEPTH`=4 and single-cycle memory, there is one fetch per cycle when decode is always ready.
- **Redirect:** with redirect in cycle R, the first request to the new PC is in R+1. The earliest new instruction is at `id_valid` in R+3.
- **Reset mid-operation:** all state clears immediately. Responses to pre-reset requests are not expected and must not be issued by the memory model.

## Structure
- **Shared package `rv_pkg`:**
  - `XLEN`=32.
  - `RV_NOP`=32'h0000_0013.
  - Default `RESET_PC`.
  - Typedef `fetch_entry_t {logic [31:0] instr; logic [31:0] pc;}`.
- **One sub-module `fetch_fifo`:**
  - Synchronous FIFO of `fetch_entry_t`, `DEPTH` entries.
  - Ports: `push`, `pop`, `flush`, `full`, `empty`, `count`.
  - `flush` takes priority over `push` in the same cycle.
- **Top level:** PC, credit and drop logic.

## Test plan
- **Reset fetch:** reset, then `RESET_PC`=0x100, memory latency 1, `id_ready`=1 → `imem_addr` 0x100,0x104,0x108… on consecutive cycles. `id_pc` 0x100 appears 2 cycles after the first grant, then one per cycle.
- **Backpressure:** `id_ready`=0 for 10 cycles → exactly 4 fetches granted, then `imem_req`=0. `id_instr`/`id_pc` stay stable. Releasing `id_ready` drains in order with no loss.
- **Redirect with fetches in flight:** memory latency 3, 3 outstanding, redirect to 0x2002 → next `imem_addr`=0x2000. The 3 stale words are dropped. The first `id_pc` seen is 0x2000.
- **Simultaneous edge:** redirect in the same cycle as rvalid and as an id handshake → the handshake completes, the returning word is dropped and the FIFO becomes empty.
- **Wrap:** `redirect_pc`=0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Async reset mid-burst:** `rst_n` pulled low between clock edges → `id_valid` and `imem_req` drop to 0 without waiting for a clock edge, and fetch restarts from `RESET_PC`.
